regfile_dump: RTL
=================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register word width.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_W  first register to dump; captured with start.
REQ-007 SHALL have port end_addr  input  ADDR_W  last register to dump; captured with start.
REQ-008 SHALL have port abort  input  1  terminate the current dump.
REQ-009 SHALL have port rd_addr  output  ADDR_W  registered address driven to the register-file read port (rs side).
REQ-010 SHALL have port rd_data  input  DATA_W  combinational register-file read data (busA side) for rd_addr.
REQ-011 SHALL have port dump_data  output  DATA_W  captured register word.
REQ-012 SHALL have port dump_addr  output  ADDR_W  address of the word on dump_data.
REQ-013 SHALL have port dump_valid  output  1  dump_data/dump_addr valid.
REQ-014 SHALL have port dump_ready  input  1  consumer accepts word when high with dump_valid.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 SHALL implement states IDLE, ADDR, HOLD, DONE.
REQ-018 IDLE with start=1 at edge N SHALL latch start_addr/end_addr, set rd_addr=start_addr, enter ADDR (busy=1 from cycle N+1).
REQ-019 ADDR SHALL last exactly one cycle; at its closing edge dump_data<=rd_data, dump_addr<=rd_addr, dump_valid<=1, enter HOLD.
REQ-020 HOLD SHALL hold dump_valid, dump_data, dump_addr stable until the edge with dump_ready=1.
REQ-021 On acceptance, if dump_addr==latched end_addr SHALL clear dump_valid and enter DONE; otherwise SHALL clear dump_valid, set rd_addr=rd_addr+1 modulo 2^ADDR_W, enter ADDR.
REQ-022 DONE SHALL assert done for exactly one cycle, then enter IDLE; busy SHALL be high during DONE.
REQ-023 Word count SHALL be ((end_addr-start_addr) mod 2^ADDR_W)+1; end_addr<start_addr wraps 15->0; end_addr==start_addr dumps one word.
REQ-024 Minimum throughput SHALL be one word per 2 cycles with dump_ready held high.
REQ-025 start while busy SHALL be ignored; start and end values SHALL not change mid-dump.
REQ-026 abort=1 in ADDR or HOLD SHALL at that edge clear dump_valid and enter IDLE without done; abort in IDLE or DONE SHALL be ignored.
REQ-027 abort and dump_ready together in HOLD SHALL be treated as abort; the word counts as not transferred.
REQ-028 rd_addr SHALL hold its last value in IDLE.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE; rd_addr=0, dump_data=0, dump_addr=0, dump_valid=0, busy=0, done=0.
REQ-030 rst SHALL take priority over start and abort and SHALL terminate a dump in progress with no done pulse.

Configuration
REQ-031 With macro REGFILE_DUMP_PARITY_EN defined SHALL add output dump_parity (1 bit, even parity: XOR of dump_data), registered with dump_data, reset 0, stable with dump_data during HOLD.
REQ-032 Without REGFILE_DUMP_PARITY_EN the dump_parity port and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reg i preloaded to 16'h1000+i, start_addr=0, end_addr=3, dump_ready=1 -> words 1000,1001,1002,1003 with dump_addr 0..3, one word every 2 cycles, done pulse one cycle after the fourth acceptance.
REQ-034 start_addr=14, end_addr=1 -> dump_addr sequence 14,15,0,1, then done.
REQ-035 start_addr=end_addr=5, dump_ready low 6 cycles then high -> dump_valid held 6+ cycles with data 1005 stable, single word, done.
REQ-036 Abort during HOLD of the second word (start 0, end 7) -> dump_valid 0 next cycle, busy 0, no done; new start then dumps correctly.
REQ-037 rst asserted mid-dump -> all outputs at reset values next cycle; start pulse while busy -> ignored, range unchanged.
REQ-038 With REGFILE_DUMP_PARITY_EN, reg 2 = 16'hFFFF and reg 3 = 16'h0001 -> dump_parity 0 and 1 respectively.

Source files
------------

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks an address range through a read port and streams words out.
// Optional REGFILE_DUMP_PARITY_EN adds an even-parity bit registered alongside dump_data.
module regfile_dump #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
`ifdef REGFILE_DUMP_PARITY_EN
  output logic              dump_parity,
`endif
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              last_w;

  // Range walk wraps naturally at 2^ADDR_W.
  assign rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign last_w    = (daddr_q == end_q);

`ifdef REGFILE_DUMP_PARITY_EN
  logic parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      end_q     <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      daddr_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REGFILE_DUMP_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            end_q     <= end_addr;
            rd_addr_q <= start_addr;
            busy_q    <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (abort) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            data_q   <= rd_data;
            daddr_q  <= rd_addr_q;
            valid_q  <= 1'b1;
`ifdef REGFILE_DUMP_PARITY_EN
            parity_q <= ^rd_data;
`endif
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          // Abort wins over a same-cycle handshake; that word is dropped.
          if (abort) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (dump_ready) begin
            valid_q <= 1'b0;
            if (last_w) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rd_addr_q <= rd_addr_d;
              state_q   <= ADDR;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr    = rd_addr_q;
  assign dump_data  = data_q;
  assign dump_addr  = daddr_q;
  assign dump_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef REGFILE_DUMP_PARITY_EN
  assign dump_parity = parity_q;
`endif

endmodule
